// File: rtl/mipi_phy_ctrl.sv
// Bring-up and supervision controller for one MIPI D-PHY receive lane.
// Optional feature macro: MIPI_PHY_CTRL_POL_AUTO_EN (automatic lane polarity flip after repeated sync failures).
module mipi_phy_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_TRIES   = 3,
    parameter int SYNC_TRIES   = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic [7:0] cfg_tx_period,
    input  logic       cfg_polarity,
    input  logic       phy_locked,
    input  logic       phy_we,
    input  logic       lp_p,
    input  logic       lp_n,
    output logic       mmcm_reset,
    output logic       phy_resetb,
    output logic       md_polarity,
    output logic [7:0] mipi_tx_period,
    output logic       link_up,
    output logic       err_lock,
    output logic [7:0] retrain_count,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MMCM_RST  = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_PHY_RST   = 3'd3;
    localparam logic [2:0] ST_WAIT_HS   = 3'd4;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd5;
    localparam logic [2:0] ST_LINKED    = 3'd6;
    localparam logic [2:0] ST_ERROR     = 3'd7;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT);
    localparam logic [7:0]  LOCK_TRIES_C = 8'(LOCK_TRIES);
    localparam logic [7:0]  SYNC_TRIES_C = 8'(SYNC_TRIES);

    logic [1:0]  locked_sync_r;
    logic [1:0]  we_sync_r;
    logic [1:0]  lpp_sync_r;
    logic [1:0]  lpn_sync_r;
    logic        locked_s;
    logic        we_s;
    logic        lpp_s;
    logic        lpn_s;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt;
    logic [7:0]  attempts_r;
    logic [7:0]  attempts_nxt;
    logic [7:0]  fail_r;
    logic [7:0]  fail_nxt;
    logic [7:0]  retrain_r;
    logic [7:0]  retrain_nxt;
`ifdef MIPI_PHY_CTRL_POL_AUTO_EN
    logic        pol_flip;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // MMCM is held in reset while idle, during its reset pulse and in ERROR.
    function automatic logic mmcm_rst_for(input logic [2:0] st);
        logic r;
        case (st)
            ST_IDLE, ST_MMCM_RST, ST_ERROR: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Deserializer runs only once its own reset pulse has completed.
    function automatic logic phy_run_for(input logic [2:0] st);
        logic r;
        case (st)
            ST_WAIT_HS, ST_WAIT_SYNC, ST_LINKED: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    assign locked_s      = locked_sync_r[1];
    assign we_s          = we_sync_r[1];
    assign lpp_s         = lpp_sync_r[1];
    assign lpn_s         = lpn_sync_r[1];
    assign state         = state_r;
    assign retrain_count = retrain_r;

    // Two-flop synchronizers for the asynchronous PHY-side inputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            locked_sync_r <= 2'b00;
            we_sync_r     <= 2'b00;
            lpp_sync_r    <= 2'b00;
            lpn_sync_r    <= 2'b00;
        end else begin
            locked_sync_r <= {locked_sync_r[0], phy_locked};
            we_sync_r     <= {we_sync_r[0], phy_we};
            lpp_sync_r    <= {lpp_sync_r[0], lp_p};
            lpn_sync_r    <= {lpn_sync_r[0], lp_n};
        end
    end

    // Next-state, counters and retry bookkeeping.
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        attempts_nxt = attempts_r;
        fail_nxt     = fail_r;
        retrain_nxt  = retrain_r;
`ifdef MIPI_PHY_CTRL_POL_AUTO_EN
        pol_flip     = 1'b0;
`endif
        if (!enable) begin
            state_nxt    = ST_IDLE;
            cnt_nxt      = 16'd0;
            attempts_nxt = 8'd0;
            fail_nxt     = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt    = ST_MMCM_RST;
                    cnt_nxt      = 16'd0;
                    attempts_nxt = 8'd0;
                    fail_nxt     = 8'd0;
                end
                ST_MMCM_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = 16'd0;
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_PHY_RST;
                        cnt_nxt   = 16'd0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        attempts_nxt = attempts_r + 8'd1;
                        cnt_nxt      = 16'd0;
                        if (attempts_nxt == LOCK_TRIES_C) begin
                            state_nxt = ST_ERROR;
                        end else begin
                            state_nxt = ST_MMCM_RST;
                        end
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end
                ST_PHY_RST: begin
                    if (!locked_s) begin
                        state_nxt = ST_MMCM_RST;
                        cnt_nxt   = 16'd0;
                    end else if (cnt_r == RST_LAST) begin
                        state_nxt = ST_WAIT_HS;
                        cnt_nxt   = 16'd0;
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end
                ST_WAIT_HS: begin
                    if (!locked_s) begin
                        state_nxt = ST_MMCM_RST;
                        cnt_nxt   = 16'd0;
                    end else if (!lpp_s && !lpn_s) begin
                        state_nxt = ST_WAIT_SYNC;
                    end else begin
                        state_nxt = ST_WAIT_HS;
                    end
                end
                ST_WAIT_SYNC: begin
                    // A write strobe wins over an LP line returning high in the same cycle.
                    if (!locked_s) begin
                        state_nxt = ST_MMCM_RST;
                        cnt_nxt   = 16'd0;
                    end else if (we_s) begin
                        state_nxt = ST_LINKED;
                        fail_nxt  = 8'd0;
                    end else if (lpp_s || lpn_s) begin
                        if ((fail_r + 8'd1) == SYNC_TRIES_C) begin
                            fail_nxt    = 8'd0;
                            retrain_nxt = sat_inc8(retrain_r);
                            state_nxt   = ST_PHY_RST;
                            cnt_nxt     = 16'd0;
`ifdef MIPI_PHY_CTRL_POL_AUTO_EN
                            pol_flip    = 1'b1;
`endif
                        end else begin
                            fail_nxt  = fail_r + 8'd1;
                            state_nxt = ST_WAIT_HS;
                        end
                    end else begin
                        state_nxt = ST_WAIT_SYNC;
                    end
                end
                ST_LINKED: begin
                    if (!locked_s) begin
                        state_nxt    = ST_MMCM_RST;
                        cnt_nxt      = 16'd0;
                        retrain_nxt  = sat_inc8(retrain_r);
                        attempts_nxt = 8'd0;
                    end else begin
                        state_nxt = ST_LINKED;
                    end
                end
                ST_ERROR: begin
                    state_nxt = ST_ERROR;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // State, counters and Moore outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            attempts_r     <= 8'd0;
            fail_r         <= 8'd0;
            retrain_r      <= 8'd0;
            mmcm_reset     <= 1'b1;
            phy_resetb     <= 1'b0;
            link_up        <= 1'b0;
            err_lock       <= 1'b0;
            mipi_tx_period <= 8'd0;
        end else begin
            state_r        <= state_nxt;
            cnt_r          <= cnt_nxt;
            attempts_r     <= attempts_nxt;
            fail_r         <= fail_nxt;
            retrain_r      <= retrain_nxt;
            mmcm_reset     <= mmcm_rst_for(state_nxt);
            phy_resetb     <= phy_run_for(state_nxt);
            link_up        <= (state_nxt == ST_LINKED);
            mipi_tx_period <= cfg_tx_period;
            if (state_nxt == ST_IDLE) begin
                err_lock <= 1'b0;
            end else if (state_nxt == ST_ERROR) begin
                err_lock <= 1'b1;
            end else begin
                err_lock <= err_lock;
            end
        end
    end

`ifdef MIPI_PHY_CTRL_POL_AUTO_EN
    // Polarity is loaded while idle and toggled on each sync-failure retrain.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            md_polarity <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            md_polarity <= cfg_polarity;
        end else if (pol_flip) begin
            md_polarity <= ~md_polarity;
        end else begin
            md_polarity <= md_polarity;
        end
    end
`else
    // Polarity is fixed by configuration in every state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            md_polarity <= 1'b0;
        end else begin
            md_polarity <= cfg_polarity;
        end
    end
`endif

endmodule

// File: tb/tb_mipi_phy_ctrl.sv
// Self-checking bench for mipi_phy_ctrl: directed table, corner sequences, then random vs. a reference model.
module tb_mipi_phy_ctrl;

    localparam int RST_CYC = 16;
    localparam int LTO     = 128;
    localparam int LTRIES  = 3;
    localparam int STRIES  = 4;

    localparam int S_IDLE = 0, S_MMCM = 1, S_WL = 2, S_PR = 3, S_WH = 4, S_WS = 5, S_LINK = 6, S_ERR = 7;

`ifdef MIPI_PHY_CTRL_POL_AUTO_EN
    localparam logic POL_AUTO = 1'b1;
`else
    localparam logic POL_AUTO = 1'b0;
`endif

    logic       clk;
    logic       resetb;
    logic       enable;
    logic [7:0] cfg_tx_period;
    logic       cfg_polarity;
    logic       phy_locked;
    logic       phy_we;
    logic       lp_p;
    logic       lp_n;
    logic       mmcm_reset;
    logic       phy_resetb;
    logic       md_polarity;
    logic [7:0] mipi_tx_period;
    logic       link_up;
    logic       err_lock;
    logic [7:0] retrain_count;
    logic [2:0] state;

    mipi_phy_ctrl #(
        .RST_CYCLES  (RST_CYC),
        .LOCK_TIMEOUT(LTO),
        .LOCK_TRIES  (LTRIES),
        .SYNC_TRIES  (STRIES)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .enable        (enable),
        .cfg_tx_period (cfg_tx_period),
        .cfg_polarity  (cfg_polarity),
        .phy_locked    (phy_locked),
        .phy_we        (phy_we),
        .lp_p          (lp_p),
        .lp_n          (lp_n),
        .mmcm_reset    (mmcm_reset),
        .phy_resetb    (phy_resetb),
        .md_polarity   (md_polarity),
        .mipi_tx_period(mipi_tx_period),
        .link_up       (link_up),
        .err_lock      (err_lock),
        .retrain_count (retrain_count),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       lk;
        logic       lpp;
        logic       lpn;
        logic       we;
        int         n;
        logic [2:0] st;
        logic       lu;
        logic       mr;
        logic       pr;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl[8];

    // Reference model: spec-level state, dwell time and retry bookkeeping.
    int         m_st;
    int         m_dwell;
    int         m_att;
    int         m_fail;
    int         m_rc;
    logic       m_err;
    logic       m_pol;
    logic [7:0] m_tx;
    logic       h_lk[2];
    logic       h_we[2];
    logic       h_lp[2];
    logic       h_ln[2];

    int entries;
    int wl_cycles;
    int seg_done;
    int prev_st;
    int lowcnt;
    int k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] want, input int budget, input string name);
        int n;
        n = 0;
        while (state !== want && n < budget) begin
            tick();
            n++;
        end
        chk(name, {29'd0, state}, {29'd0, want});
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_dwell = 0; m_att = 0; m_fail = 0; m_rc = 0;
        m_err = 1'b0; m_pol = 1'b0; m_tx = 8'd0;
        for (int i = 0; i < 2; i++) begin
            h_lk[i] = 1'b0; h_we[i] = 1'b0; h_lp[i] = 1'b0; h_ln[i] = 1'b0;
        end
    endtask

    // Advances the model by one clock edge with the inputs the DUT will sample at that edge.
    task automatic model_step(input logic en, input logic lk, input logic lp, input logic ln,
                              input logic we, input logic cp, input logic [7:0] ct);
        logic lks, wes, lps, lns, flip;
        int nxt;
        lks = h_lk[1]; h_lk[1] = h_lk[0]; h_lk[0] = lk;
        wes = h_we[1]; h_we[1] = h_we[0]; h_we[0] = we;
        lps = h_lp[1]; h_lp[1] = h_lp[0]; h_lp[0] = lp;
        lns = h_ln[1]; h_ln[1] = h_ln[0]; h_ln[0] = ln;
        nxt  = m_st;
        flip = 1'b0;
        if (!en) begin
            nxt = S_IDLE; m_att = 0; m_fail = 0;
        end else if (m_st == S_IDLE) begin
            nxt = S_MMCM; m_att = 0; m_fail = 0;
        end else if (m_st == S_MMCM) begin
            if (m_dwell + 1 >= RST_CYC) nxt = S_WL;
        end else if (m_st == S_WL) begin
            if (lks) nxt = S_PR;
            else if (m_dwell == LTO) begin
                m_att++;
                nxt = (m_att == LTRIES) ? S_ERR : S_MMCM;
            end
        end else if (m_st == S_PR) begin
            if (!lks) nxt = S_MMCM;
            else if (m_dwell + 1 >= RST_CYC) nxt = S_WH;
        end else if (m_st == S_WH) begin
            if (!lks) nxt = S_MMCM;
            else if (!lps && !lns) nxt = S_WS;
        end else if (m_st == S_WS) begin
            if (!lks) nxt = S_MMCM;
            else if (wes) begin
                nxt = S_LINK; m_fail = 0;
            end else if (lps || lns) begin
                m_fail++;
                if (m_fail == STRIES) begin
                    m_fail = 0; flip = 1'b1; nxt = S_PR;
                    if (m_rc < 255) m_rc++;
                end else begin
                    nxt = S_WH;
                end
            end
        end else if (m_st == S_LINK) begin
            if (!lks) begin
                nxt = S_MMCM; m_att = 0;
                if (m_rc < 255) m_rc++;
            end
        end
        m_dwell = (nxt == m_st) ? m_dwell + 1 : 0;
        m_st    = nxt;
        if (m_st == S_IDLE) m_err = 1'b0;
        else if (m_st == S_ERR) m_err = 1'b1;
        if (POL_AUTO) begin
            if (m_st == S_IDLE) m_pol = cp;
            else if (flip) m_pol = ~m_pol;
        end else begin
            m_pol = cp;
        end
        m_tx = ct;
    endtask

    task automatic apply_in(input logic en, input logic lk, input logic lpp, input logic lpn, input logic we);
        enable = en; phy_locked = lk; lp_p = lpp; lp_n = lpn; phy_we = we;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5, 3'd4, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3'd4, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3'd5, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3'd5, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3'd6, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5, 3'd6, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3'd6, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd1, 1'b0, 1'b1, 1'b0, 8'd1};

        resetb = 1'b1; cfg_tx_period = 8'h5A; cfg_polarity = 1'b0;
        apply_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2 resetb = 1'b0;
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_outs", {mmcm_reset, phy_resetb, md_polarity, link_up, err_lock},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_tx", {24'd0, mipi_tx_period}, 32'd0);
        chk("rst_rc", {24'd0, retrain_count}, 32'd0);
        tick(); tick();
        chk("rst_hold", {29'd0, state}, 32'd0);
        #2 resetb = 1'b1;
        tick();
        chk("tx_copy", {24'd0, mipi_tx_period}, 32'h5A);
        cfg_polarity = 1'b1;
        tick();
        chk("idle_pol1", {31'd0, md_polarity}, 32'd1);
        cfg_polarity = 1'b0;
        tick();
        chk("idle_pol0", {31'd0, md_polarity}, 32'd0);

        // Lock on first try.
        enable = 1'b1;
        tick();
        chk("mmcm_enter", {29'd0, state}, 32'd1);
        repeat (15) tick();
        chk("mmcm_last", {29'd0, state, mmcm_reset}, {28'd0, 3'd1, 1'b1});
        tick();
        chk("wl_enter", {29'd0, state, mmcm_reset}, {28'd0, 3'd2, 1'b0});
        repeat (100) tick();
        phy_locked = 1'b1;
        tick(); tick();
        chk("lock_lat2", {29'd0, state}, 32'd2);
        tick();
        chk("pr_enter", {29'd0, state, phy_resetb}, {28'd0, 3'd3, 1'b0});
        repeat (15) tick();
        chk("pr_last", {29'd0, state, phy_resetb}, {28'd0, 3'd3, 1'b0});
        tick();
        chk("wh_enter", {29'd0, state, phy_resetb}, {28'd0, 3'd4, 1'b1});
        chk("first_try_flags", {23'd0, err_lock, retrain_count}, 32'd0);

        // Normal link and loss of lock, table driven.
        for (int i = 0; i < 8; i++) begin
            apply_in(tbl[i].en, tbl[i].lk, tbl[i].lpp, tbl[i].lpn, tbl[i].we);
            repeat (tbl[i].n) tick();
            chk($sformatf("tbl%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
            chk($sformatf("tbl%0d_link", i), {31'd0, link_up}, {31'd0, tbl[i].lu});
            chk($sformatf("tbl%0d_mmcm", i), {31'd0, mmcm_reset}, {31'd0, tbl[i].mr});
            chk($sformatf("tbl%0d_phyrb", i), {31'd0, phy_resetb}, {31'd0, tbl[i].pr});
            chk($sformatf("tbl%0d_rc", i), {24'd0, retrain_count}, {24'd0, tbl[i].rc});
        end

        // Asynchronous reset while linked.
        phy_locked = 1'b1;
        wait_state(3'd6, 300, "relink");
        #3 resetb = 1'b0;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_outs", {mmcm_reset, phy_resetb, md_polarity, link_up, err_lock},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("arst_rc_tx", {16'd0, retrain_count, mipi_tx_period}, 32'd0);
        #2 resetb = 1'b1;
        tick();
        chk("arst_restart", {29'd0, state, mmcm_reset}, {28'd0, 3'd1, 1'b1});

        // Polarity retry after repeated sync failures.
        phy_we = 1'b0; lp_p = 1'b1; lp_n = 1'b1;
        wait_state(3'd4, 300, "pol_wh");
        for (int b = 0; b < 4; b++) begin
            lp_p = 1'b0; lp_n = 1'b0;
            repeat (3) tick();
            chk($sformatf("burst%0d_ws", b), {29'd0, state}, 32'd5);
            tick();
            lp_p = 1'b1; lp_n = 1'b1;
            repeat (3) tick();
            if (b < 3) begin
                chk($sformatf("burst%0d_back", b), {29'd0, state}, 32'd4);
                tick();
            end else begin
                chk("retry_state", {29'd0, state, phy_resetb}, {28'd0, 3'd3, 1'b0});
                chk("retry_rc", {24'd0, retrain_count}, 32'd1);
                chk("retry_pol", {31'd0, md_polarity}, {31'd0, POL_AUTO});
            end
        end
        lowcnt = 1;
        k = 0;
        while (phy_resetb === 1'b0 && k < 100) begin
            tick();
            k++;
            if (phy_resetb === 1'b0) lowcnt++;
        end
        chk("retry_pulse_len", lowcnt, RST_CYC);
        chk("retry_pol_hold", {31'd0, md_polarity}, {31'd0, POL_AUTO});

        // Lock loss outside LINKED, then lock failure into ERROR.
        phy_locked = 1'b0;
        repeat (3) tick();
        chk("drop_wh_state", {29'd0, state}, 32'd1);
        chk("drop_wh_rc", {24'd0, retrain_count}, 32'd1);
        entries = 1; wl_cycles = 0; seg_done = 0; prev_st = 1; k = 0;
        while (state !== 3'd7 && k < 1500) begin
            tick();
            k++;
            if (state == 3'd2 && seg_done == 0) wl_cycles++;
            if (state != 3'd2 && wl_cycles > 0) seg_done = 1;
            if (state == 3'd1 && prev_st != 1) entries++;
            prev_st = int'(state);
        end
        chk("err_state", {29'd0, state}, 32'd7);
        chk("err_pulses", entries, LTRIES);
        chk("wl_dwell", wl_cycles, LTO + 1);
        chk("err_outs", {err_lock, mmcm_reset, phy_resetb}, {1'b1, 1'b1, 1'b0});
        repeat (5) tick();
        chk("err_hold", {29'd0, state}, 32'd7);
        enable = 1'b0;
        tick();
        chk("err_clear", {29'd0, state, err_lock}, {28'd0, 3'd0, 1'b0});

        // Random stimulus against the reference model.
        resetb = 1'b0;
        model_reset();
        tick();
        resetb = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if (c == 5) enable = 1'b1;
            if (phy_locked ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 249) == 0))
                phy_locked = ~phy_locked;
            if ($urandom_range(0, 4) == 0) begin
                lp_p = 1'($urandom_range(0, 1));
                lp_n = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) phy_we = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) cfg_polarity = ~cfg_polarity;
            cfg_tx_period = 8'($urandom_range(0, 255));
            model_step(enable, phy_locked, lp_p, lp_n, phy_we, cfg_polarity, cfg_tx_period);
            tick();
            chk($sformatf("rand_c%0d", c),
                {8'd0, mmcm_reset, phy_resetb, md_polarity, mipi_tx_period, link_up, err_lock,
                 retrain_count, state},
                {8'd0, (m_st == S_IDLE || m_st == S_MMCM || m_st == S_ERR),
                 (m_st == S_WH || m_st == S_WS || m_st == S_LINK), m_pol, m_tx,
                 (m_st == S_LINK), m_err, 8'(m_rc), 3'(m_st)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
